// File: rtl/dec_64b_arb.sv
// rtl/dec_64b_arb.sv - round-robin arbiter sharing one 6-to-64 one-hot decoder

module dec_64b #(
    parameter int REG_OUT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [5:0]  in_data_i,
    input  logic        in_valid_i,
    output logic [63:0] out_data_o,
    output logic        out_valid_o
);
    logic [63:0] onehot;

    assign onehot = in_valid_i ? (64'd1 << in_data_i) : 64'd0;

    generate
        if (REG_OUT != 0) begin : g_reg
            logic [63:0] data_q, data_d;
            logic        valid_q, valid_d;

            always_comb begin
                data_d  = onehot;
                valid_d = in_valid_i;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign out_data_o  = data_q;
            assign out_valid_o = valid_q;
        end else begin : g_comb
            assign out_data_o  = onehot;
            assign out_valid_o = in_valid_i;
        end
    endgenerate
endmodule

module dec_64b_arb #(
    parameter  int NUM_REQ = 4,
    parameter  int REG_OUT = 1,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ*6-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [63:0]          out_data_o,
    output logic [ID_W-1:0]      out_id_o,
    output logic                 out_last_o,
    output logic                 out_valid_o
);
    typedef enum logic {ST_IDLE = 1'b0, ST_LOCK = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   own_q, own_d;

    logic              gnt_vld;
    logic [ID_W-1:0]   gnt_id;
    logic [ID_W-1:0]   cand;
    logic              acc;
    logic              acc_last;
    logic [5:0]        acc_data;

    // Descending scan so the nearest valid requester after ptr is the last to assign.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        cand    = '0;
        if (state_q == ST_LOCK) begin
            gnt_vld = req_valid_i[own_q];
            gnt_id  = own_q;
        end else begin
            for (int off = NUM_REQ; off >= 1; off--) begin
                cand = ID_W'((int'(ptr_q) + off) % NUM_REQ);
                if (req_valid_i[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
    end

    assign acc         = gnt_vld & ~rst_i;
    assign req_ready_o = acc ? (NUM_REQ'(1) << gnt_id) : '0;
    assign acc_last    = req_last_i[gnt_id];
    assign acc_data    = req_data_i[6*int'(gnt_id) +: 6];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        if (acc) begin
            if (acc_last) begin
                ptr_d   = gnt_id;
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                own_d   = gnt_id;
                state_d = ST_LOCK;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            ptr_q   <= ID_W'(NUM_REQ - 1);
            own_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
        end
    end

    dec_64b #(
        .REG_OUT (REG_OUT)
    ) u_dec (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   (acc_data),
        .in_valid_i  (acc),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o)
    );

    // Tag delay line matches the decoder latency so id/last line up with out_valid_o.
    generate
        if (REG_OUT != 0) begin : g_tag_reg
            logic [ID_W-1:0] id_q, id_d;
            logic            last_q, last_d;

            always_comb begin
                id_d   = acc ? gnt_id : '0;
                last_d = acc & acc_last;
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    id_q   <= '0;
                    last_q <= 1'b0;
                end else begin
                    id_q   <= id_d;
                    last_q <= last_d;
                end
            end

            assign out_id_o   = id_q;
            assign out_last_o = last_q;
        end else begin : g_tag_comb
            assign out_id_o   = acc ? gnt_id : '0;
            assign out_last_o = acc & acc_last;
        end
    endgenerate
endmodule
